bky_chain_loader: RTL and testbench
===================================

Name: bky_chain_loader

Overview:
- Parametrised successor to the single-chain Buckeye loader.
- Buffers WORD_W-bit words written from the CLK40 domain in an internal FIFO. On START it shifts exactly NWORDS words out serially on a shift clock generated internally (CLK40 / (2*DIV)).
- Selectable bit order.
- Captures the chain's returned serial data (SDIN) into readback words, and flags under-filled starts and FIFO overflow.
- Sits between the JTAG/BPI register interface and the Buckeye shift chains.

Parameters:
- WORD_W, 16, word width and bits shifted per word (2..32)
- NWORDS, 6, words shifted per load operation (1..2**DEPTH_LOG2)
- DEPTH_LOG2, 6, FIFO depth = 2**DEPTH_LOG2 words
- DIV, 20, half-period of SHCK in CLK40 cycles (>=1); DIV=20 gives 1 MHz
- LSB_FIRST, 1, 1 = bit 0 shifted first, 0 = bit WORD_W-1 first

Ports:
- CLK40  in  1  sole clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- WR_EN  in  1  write WR_DATA into the FIFO
- WR_DATA  in  WORD_W  FIFO write data
- START  in  1  begin a load; single-cycle pulse
- CLR_DONE  in  1  clear DONE
- SDIN  in  1  serial return data from the chain
- SHCK  out  1  shift clock to the chain; idle low
- SHCK_ENA  out  1  high while in SHIFT
- SDATA  out  1  serial data; changes only while SHCK is low
- BUSY  out  1  state != IDLE
- DONE  out  1  sticky load-complete flag
- UNDERRUN  out  1  sticky: START arrived with FIFO count < NWORDS
- OVERFLOW  out  1  sticky: WR_EN while FIFO full
- FULL  out  1  FIFO full
- EMPTY  out  1  FIFO empty
- WCNT  out  DEPTH_LOG2+1  FIFO word count
- RB_DATA  out  WORD_W  last completed readback word
- RB_VALID  out  1  one-cycle pulse when RB_DATA updates

Behaviour:
- Reset (RST_N low, asynchronous):
  - State IDLE; FIFO emptied (WCNT=0, EMPTY=1, FULL=0).
  - SHCK, SHCK_ENA, SDATA, BUSY, DONE, UNDERRUN, OVERFLOW and RB_VALID are 0; RB_DATA = 0.
  - Divider, bit and word counters cleared.
  - Reset mid-load aborts immediately and discards FIFO contents.
- FIFO:
  - Synchronous, first-word-fall-through.
  - Write accepted when WR_EN=1 and FULL=0.
  - WR_EN while full: write dropped, OVERFLOW set.
  - Push and pop in the same cycle: WCNT unchanged. Writes are accepted during BUSY.
  - Pointers wrap modulo 2**DEPTH_LOG2.
- FSM states: IDLE, LOAD, SHIFT, FINISH.
  - IDLE:
    - START with WCNT>=NWORDS: go to LOAD; DONE cleared.
    - START with WCNT<NWORDS: UNDERRUN set, stay in IDLE, no pop.
  - START while BUSY is ignored.
  - LOAD (1 cycle):
    - Pop the FIFO head into the shift register; clear the divider and bit counter.
    - SDATA = first bit of the word, per LSB_FIRST.
    - Go to SHIFT.
  - SHIFT, per bit:
    - SHCK low for DIV cycles, then high for DIV cycles.
    - SDIN is sampled on the CLK40 edge where SHCK rises and shifted into the readback register in the same bit order.
    - On the edge where SHCK falls, SDATA advances to the next bit.
    - After WORD_W bits, SHCK stays low:
      - RB_DATA loads and RB_VALID pulses for one cycle.
      - Word counter increments.
      - If the word counter equals NWORDS, go to FINISH; otherwise go to LOAD.
  - FINISH (1 cycle): set DONE, clear the word counter, go to IDLE.
- Timing:
  - Each word takes 1 + 2*DIV*WORD_W cycles.
  - With START sampled at cycle T, DONE is first high at T + 2 + NWORDS*(1 + 2*DIV*WORD_W).
- DONE:
  - Cleared by CLR_DONE or an accepted START.
  - If set_done and CLR_DONE occur in the same cycle, set wins.
- SDATA holds the last shifted bit after FINISH. It is don't-care to the chain; the bench checks only bits driven while SHCK_ENA=1.
- UNDERRUN and OVERFLOW are cleared only by reset.

Test Plan:
1. LSB_FIRST=1, WORD_W=16, NWORDS=2, DIV=2; write 16'hA5C3 then 16'h0F01; START at T.
   - SDATA sampled at SHCK rises gives bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then the 16'h0F01 sequence.
   - DONE is first high at T+132; WCNT=0.
2. Same load with SDIN tied to SDATA delayed by one SHCK period.
   - RB_VALID pulses twice.
   - Second RB_DATA = {16'h0F01 shifted one bit, first bit = last bit of 16'hA5C3}.
3. LSB_FIRST=0, NWORDS=1; write 16'h8001; START.
   - First SDATA bit = 1, next 14 bits = 0, last bit = 1.
   - Exactly 16 SHCK rising edges.
4. Write one word with NWORDS=2; START.
   - UNDERRUN=1, BUSY stays 0, no SHCK edges, WCNT=1.
5. DEPTH_LOG2=2; write 5 words back-to-back.
   - FULL=1 after the 4th; 5th dropped; OVERFLOW=1; WCNT=4.
6. Mid-SHIFT: pulse START (ignored, DONE unaffected), then assert RST_N low asynchronously.
   - All outputs return to 0 within the reset assertion; WCNT=0.
   - A subsequent fresh load completes normally.

Source files
------------

// File: rtl/bky_chain_loader.sv
// Buckeye chain loader: buffers WORD_W-bit words in a FWFT FIFO and shifts NWORDS of them
// out serially on a divided shift clock, capturing the chain's return data into readback words.
module bky_chain_loader #(
   parameter int unsigned WORD_W     = 16,
   parameter int unsigned NWORDS     = 6,
   parameter int unsigned DEPTH_LOG2 = 6,
   parameter int unsigned DIV        = 20,
   parameter int unsigned LSB_FIRST  = 1
) (
   input  logic                  CLK40,
   input  logic                  RST_N,
   input  logic                  WR_EN,
   input  logic [WORD_W-1:0]     WR_DATA,
   input  logic                  START,
   input  logic                  CLR_DONE,
   input  logic                  SDIN,
   output logic                  SHCK,
   output logic                  SHCK_ENA,
   output logic                  SDATA,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  UNDERRUN,
   output logic                  OVERFLOW,
   output logic                  FULL,
   output logic                  EMPTY,
   output logic [DEPTH_LOG2:0]   WCNT,
   output logic [WORD_W-1:0]     RB_DATA,
   output logic                  RB_VALID
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
   localparam int unsigned DIV_W = $clog2(DIV + 1);
   localparam int unsigned BIT_W = $clog2(WORD_W);
   localparam int unsigned WC_W  = $clog2(NWORDS + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_FINISH} state_t;

   state_t                  state_q, state_d;
   logic [WORD_W-1:0]       mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]        wcnt_d;
   logic [DIV_W-1:0]        div_q, div_d;
   logic [BIT_W-1:0]        bit_q, bit_d;
   logic [WC_W-1:0]         word_q, word_d, word_inc;
   logic [WORD_W-1:0]       sh_q, sh_d, rb_sh_q, rb_sh_d, rb_data_d, head_c;
   logic                    push_c, pop_c;
   logic                    shck_d, sdata_d, done_d, underrun_d, overflow_d, rb_valid_d;
   logic                    full_d, empty_d, shck_ena_d, busy_d;

   assign head_c   = mem[rd_ptr_q];
   assign push_c   = WR_EN && !FULL;
   assign word_inc = word_q + WC_W'(1);

   // FIFO storage carries no reset; occupancy is defined solely by the pointers and count
   always_ff @(posedge CLK40) begin
      if (push_c) mem[wr_ptr_q] <= WR_DATA;
   end

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      word_d     = word_q;
      sh_d       = sh_q;
      rb_sh_d    = rb_sh_q;
      rb_data_d  = RB_DATA;
      rb_valid_d = 1'b0;
      sdata_d    = SDATA;
      shck_d     = SHCK;
      done_d     = DONE;
      underrun_d = UNDERRUN;
      overflow_d = OVERFLOW || (WR_EN && FULL);
      pop_c      = 1'b0;

      if (CLR_DONE) done_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               if (WCNT >= CNT_W'(NWORDS)) begin
                  state_d = S_LOAD;
                  done_d  = 1'b0;
               end else begin
                  underrun_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            pop_c   = 1'b1;
            sh_d    = head_c;
            div_d   = '0;
            bit_d   = '0;
            shck_d  = 1'b0;
            sdata_d = (LSB_FIRST != 0) ? head_c[0] : head_c[WORD_W-1];
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (div_q == DIV_W'(DIV - 1)) begin
               div_d = '0;
               if (!SHCK) begin
                  // rising SHCK: capture the chain's return bit
                  shck_d = 1'b1;
                  if (LSB_FIRST != 0) rb_sh_d = {SDIN, rb_sh_q[WORD_W-1:1]};
                  else                rb_sh_d = {rb_sh_q[WORD_W-2:0], SDIN};
               end else begin
                  shck_d = 1'b0;
                  if (bit_q == BIT_W'(WORD_W - 1)) begin
                     rb_data_d  = rb_sh_q;
                     rb_valid_d = 1'b1;
                     word_d     = word_inc;
                     state_d    = (word_inc == WC_W'(NWORDS)) ? S_FINISH : S_LOAD;
                  end else begin
                     bit_d = bit_q + BIT_W'(1);
                     if (LSB_FIRST != 0) begin
                        sh_d    = sh_q >> 1;
                        sdata_d = sh_q[1];
                     end else begin
                        sh_d    = sh_q << 1;
                        sdata_d = sh_q[WORD_W-2];
                     end
                  end
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_FINISH: begin
            done_d  = 1'b1;
            word_d  = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      wr_ptr_d = push_c ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
      rd_ptr_d = pop_c  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
      case ({push_c, pop_c})
         2'b10:   wcnt_d = WCNT + CNT_W'(1);
         2'b01:   wcnt_d = WCNT - CNT_W'(1);
         default: wcnt_d = WCNT;
      endcase
      full_d     = (wcnt_d == CNT_W'(DEPTH));
      empty_d    = (wcnt_d == '0);
      shck_ena_d = (state_d == S_SHIFT);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK40 or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         WCNT     <= '0;
         FULL     <= 1'b0;
         EMPTY    <= 1'b1;
         div_q    <= '0;
         bit_q    <= '0;
         word_q   <= '0;
         sh_q     <= '0;
         rb_sh_q  <= '0;
         RB_DATA  <= '0;
         RB_VALID <= 1'b0;
         SDATA    <= 1'b0;
         SHCK     <= 1'b0;
         SHCK_ENA <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         UNDERRUN <= 1'b0;
         OVERFLOW <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         WCNT     <= wcnt_d;
         FULL     <= full_d;
         EMPTY    <= empty_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         word_q   <= word_d;
         sh_q     <= sh_d;
         rb_sh_q  <= rb_sh_d;
         RB_DATA  <= rb_data_d;
         RB_VALID <= rb_valid_d;
         SDATA    <= sdata_d;
         SHCK     <= shck_d;
         SHCK_ENA <= shck_ena_d;
         BUSY     <= busy_d;
         DONE     <= done_d;
         UNDERRUN <= underrun_d;
         OVERFLOW <= overflow_d;
      end
   end

endmodule

// File: tb/tb_bky_chain_loader.sv
// Directed bench for bky_chain_loader: an LSB-first instance with SDIN looped back one SHCK
// period late, and an MSB-first single-word instance.
module tb_bky_chain_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        a_wr_en = 1'b0, a_start = 1'b0, a_clr = 1'b0;
   logic [15:0] a_wr_data = '0;
   logic        a_sdin = 1'b0;
   logic        a_shck, a_shck_ena, a_sdata, a_busy, a_done, a_underrun, a_overflow;
   logic        a_full, a_empty, a_rb_valid;
   logic [2:0]  a_wcnt;
   logic [15:0] a_rb_data;

   logic        b_wr_en = 1'b0, b_start = 1'b0;
   logic [15:0] b_wr_data = '0;
   logic        b_shck, b_shck_ena, b_sdata, b_busy, b_done, b_underrun, b_overflow;
   logic        b_full, b_empty, b_rb_valid;
   logic [2:0]  b_wcnt;
   logic [15:0] b_rb_data;

   bky_chain_loader #(.WORD_W(16), .NWORDS(2), .DEPTH_LOG2(2), .DIV(2), .LSB_FIRST(1)) dut_a (
      .CLK40(clk), .RST_N(rst_n), .WR_EN(a_wr_en), .WR_DATA(a_wr_data), .START(a_start),
      .CLR_DONE(a_clr), .SDIN(a_sdin), .SHCK(a_shck), .SHCK_ENA(a_shck_ena), .SDATA(a_sdata),
      .BUSY(a_busy), .DONE(a_done), .UNDERRUN(a_underrun), .OVERFLOW(a_overflow),
      .FULL(a_full), .EMPTY(a_empty), .WCNT(a_wcnt), .RB_DATA(a_rb_data), .RB_VALID(a_rb_valid));

   bky_chain_loader #(.WORD_W(16), .NWORDS(1), .DEPTH_LOG2(2), .DIV(2), .LSB_FIRST(0)) dut_b (
      .CLK40(clk), .RST_N(rst_n), .WR_EN(b_wr_en), .WR_DATA(b_wr_data), .START(b_start),
      .CLR_DONE(1'b0), .SDIN(1'b0), .SHCK(b_shck), .SHCK_ENA(b_shck_ena), .SDATA(b_sdata),
      .BUSY(b_busy), .DONE(b_done), .UNDERRUN(b_underrun), .OVERFLOW(b_overflow),
      .FULL(b_full), .EMPTY(b_empty), .WCNT(b_wcnt), .RB_DATA(b_rb_data), .RB_VALID(b_rb_valid));

   int   n_tests = 0;
   int   n_fail  = 0;
   logic a_shck_prev = 1'b0, b_shck_prev = 1'b0;
   int   a_rises = 0, b_rises = 0;
   logic a_bits [$];
   logic b_bits [$];
   logic [15:0] a_rb_q [$];

   // Monitor on the falling CLK40 edge: SDATA at each SHCK rise, readback words, loopback SDIN
   always @(negedge clk) begin
      if (a_shck && !a_shck_prev) begin
         a_bits.push_back(a_sdata);
         a_rises <= a_rises + 1;
         a_sdin  <= a_sdata;
      end
      if (b_shck && !b_shck_prev) begin
         b_bits.push_back(b_sdata);
         b_rises <= b_rises + 1;
      end
      if (a_rb_valid) a_rb_q.push_back(a_rb_data);
      a_shck_prev <= a_shck;
      b_shck_prev <= b_shck;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_write(input logic [15:0] w);
      a_wr_en = 1'b1; a_wr_data = w;
      tick();
      a_wr_en = 1'b0;
   endtask

   task automatic a_wait_done(input int max_cycles);
      int n = 0;
      while (!a_done && n < max_cycles) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] w0, w1, wb;
      int base, rbase, r0, early;
      logic busy_seen;
      w0 = 16'hA5C3; w1 = 16'h0F01; wb = 16'h8001;

      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check_val("rst_wcnt",  a_wcnt, 0);
      check_val("rst_empty", a_empty, 1);
      check_val("rst_full",  a_full, 0);
      check_val("rst_flags", {a_shck, a_shck_ena, a_busy, a_done, a_rb_valid}, 0);
      check_val("rst_rbdata", a_rb_data, 0);

      // Two-word LSB-first load with SDIN looped back
      a_write(w0);
      a_write(w1);
      check_val("t1_wcnt_pre", a_wcnt, 2);
      base = a_bits.size(); rbase = a_rb_q.size();
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      early = 0;
      for (int i = 0; i < 130; i++) begin
         tick();
         if (a_done) early++;
      end
      check_val("t1_done_early", early, 0);
      tick();
      check_val("t1_done_at_132", a_done, 1);
      check_val("t1_wcnt_post", a_wcnt, 0);
      check_val("t1_busy_post", a_busy, 0);
      check_val("t1_nbits", a_bits.size() - base, 32);
      for (int i = 0; i < 32; i++)
         if (base + i < a_bits.size())
            check_val($sformatf("t1_bit%0d", i), a_bits[base+i], (i < 16) ? w0[i] : w1[i-16]);
      check_val("t2_rb_count", a_rb_q.size() - rbase, 2);
      if (a_rb_q.size() >= rbase + 2) begin
         check_val("t2_rb0", a_rb_q[rbase],   16'h4B86);
         check_val("t2_rb1", a_rb_q[rbase+1], 16'h1E03);
      end

      // MSB-first single word
      b_wr_en = 1'b1; b_wr_data = wb;
      tick();
      b_wr_en = 1'b0;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      for (int i = 0; i < 200 && !b_done; i++) tick();
      check_val("t3_done", b_done, 1);
      check_val("t3_rises", b_rises, 16);
      check_val("t3_nbits", b_bits.size(), 16);
      for (int i = 0; i < 16; i++)
         if (i < b_bits.size())
            check_val($sformatf("t3_bit%0d", i), b_bits[i], wb[15-i]);

      // Under-filled START
      r0 = a_rises;
      a_write(16'h1234);
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      busy_seen = a_busy;
      for (int i = 0; i < 10; i++) begin
         tick();
         busy_seen = busy_seen | a_busy;
      end
      check_val("t4_underrun", a_underrun, 1);
      check_val("t4_busy", busy_seen, 0);
      check_val("t4_rises", a_rises - r0, 0);
      check_val("t4_wcnt", a_wcnt, 1);
      check_val("t4_done_kept", a_done, 1);
      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      check_val("t4_clr_done", a_done, 0);

      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check_val("t5_rst_wcnt", a_wcnt, 0);
      check_val("t5_rst_underrun", a_underrun, 0);

      // Overfill a 4-deep FIFO
      a_wr_en = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         a_wr_data = 16'(16'h1111 * i);
         tick();
         if (i == 3) check_val("t5_full_at3", a_full, 0);
         if (i == 4) begin
            check_val("t5_full_at4", a_full, 1);
            check_val("t5_ovf_at4", a_overflow, 0);
         end
      end
      a_wr_en = 1'b0;
      check_val("t5_overflow", a_overflow, 1);
      check_val("t5_wcnt", a_wcnt, 4);

      // Ignored START mid-SHIFT, then asynchronous reset
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      repeat (20) tick();
      check_val("t6_shck_ena", a_shck_ena, 1);
      check_val("t6_wcnt_mid", a_wcnt, 3);
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      repeat (3) tick();
      check_val("t6_wcnt_ign", a_wcnt, 3);
      check_val("t6_done_ign", a_done, 0);
      check_val("t6_busy_ign", a_busy, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_val("t6_rst_ctrl", {a_shck, a_shck_ena, a_sdata, a_busy, a_done}, 0);
      check_val("t6_rst_flags", {a_underrun, a_overflow, a_rb_valid, a_full}, 0);
      check_val("t6_rst_rb", a_rb_data, 0);
      check_val("t6_rst_wcnt", a_wcnt, 0);
      check_val("t6_rst_empty", a_empty, 1);
      tick();
      rst_n = 1'b1;
      tick();

      a_write(w0);
      a_write(w1);
      base = a_bits.size();
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      a_wait_done(300);
      check_val("t6_fresh_done", a_done, 1);
      check_val("t6_fresh_wcnt", a_wcnt, 0);
      check_val("t6_fresh_nbits", a_bits.size() - base, 32);
      for (int i = 0; i < 32; i += 5)
         if (base + i < a_bits.size())
            check_val($sformatf("t6_bit%0d", i), a_bits[base+i], (i < 16) ? w0[i] : w1[i-16]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
